// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared widths, fetch FSM states and queue entry type
package riscv_fetch_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 64'd4;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous FIFO of fetched {pc, instr} entries
module fetch_queue
   import riscv_fetch_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   input  logic               flush,
   output fetch_entry_t       head,
   output logic               full,
   output logic               empty,
   output logic [CNT_W-1:0]   count
);

   fetch_entry_t       mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // A push into a full queue is only legal when the head leaves in the same cycle.
   assign do_push = push && !flush && (!full || pop);
   assign do_pop  = pop && !empty;

   // Entry storage needs no reset; the empty flag masks stale contents.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; flush beats push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - fetch PC owner, imem sequencer and decode-side queue
module instruction_fetch_controller
   import riscv_fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int          QUEUE_DEPTH = 2,
   parameter int          MEM_BYTES   = 16
) (
   input  logic          clk,
   input  logic          reset,
   output logic [63:0]   imem_addr,
   input  logic [31:0]   imem_rdata,
   input  logic          redirect_valid,
   input  logic [63:0]   redirect_pc,
   output logic          if_valid,
   input  logic          if_ready,
   output logic [31:0]   if_instr,
   output logic [63:0]   if_pc,
   output logic          fetch_fault
);

   localparam int              CNT_W   = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES) - PC_STEP;

   fetch_state_t       state_q;
   fetch_state_t       state_d;
   logic [XLEN-1:0]    fetch_pc;
   logic [XLEN-1:0]    pc_d;
   logic               pc_legal;
   logic               pop;
   logic               push;
   logic               space;
   fetch_entry_t       push_data;
   fetch_entry_t       head;
   logic               q_full;
   logic               q_empty;
   logic [CNT_W-1:0]   q_count;

   assign imem_addr   = fetch_pc;
   assign pc_legal    = (fetch_pc[1:0] == 2'b00) && (fetch_pc <= LAST_PC);
   assign if_valid    = (q_count != '0);
   assign pop         = if_valid && if_ready;
   assign space       = !q_full || pop;
   assign if_instr    = q_empty ? '0 : head.instr;
   assign if_pc       = q_empty ? '0 : head.pc;
   assign fetch_fault = (state_q == FAULT);
   assign push_data   = '{pc: fetch_pc, instr: imem_rdata};

   // Redirect wins over everything; otherwise an illegal PC faults and a legal one fetches when there is room.
   always_comb begin
      state_d = state_q;
      pc_d    = fetch_pc;
      push    = 1'b0;
      if (redirect_valid) begin
         state_d = RUN;
         pc_d    = redirect_pc;
      end else if (state_q == RUN) begin
         if (!pc_legal) begin
            state_d = FAULT;
         end else if (space) begin
            push = 1'b1;
            pc_d = fetch_pc + PC_STEP;
         end
      end
   end

   // Fetch state and PC registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= RUN;
         fetch_pc <= RESET_PC;
      end else begin
         state_q  <= state_d;
         fetch_pc <= pc_d;
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count)
   );

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb/tb_instruction_fetch_controller.sv - directed scoreboard bench for instruction_fetch_controller
module tb_instruction_fetch_controller;

   logic          clk = 1'b0;
   logic          reset;
   logic [63:0]   imem_addr;
   logic [31:0]   imem_rdata;
   logic          redirect_valid;
   logic [63:0]   redirect_pc;
   logic          if_valid;
   logic          if_ready;
   logic [31:0]   if_instr;
   logic [63:0]   if_pc;
   logic          fetch_fault;

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [63:0]   sb [$];
   logic [7:0]    mem [16];

   instruction_fetch_controller #(
      .RESET_PC    (64'h0),
      .QUEUE_DEPTH (2),
      .MEM_BYTES   (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   // Byte-wide memory, little-endian word assembly, zero outside the array.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [31:0] w;
      logic [63:0] ad;
      w = '0;
      for (int b = 0; b < 4; b++) begin
         ad = a + 64'(b);
         if (ad < 64'd16) w[8*b +: 8] = mem[ad[3:0]];
      end
      return w;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   // Memory byte at address i holds 8'hA0 + i.
   function automatic logic [31:0] exp_instr(input logic [63:0] pc);
      logic [7:0] b0;
      b0 = 8'hA0 + pc[7:0];
      return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [63:0] e;
      if (if_valid === 1'b1 && if_ready === 1'b1) begin
         n_assert++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_underflow observed pc=%0h expected=no_output", if_pc);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("pop_pc", if_pc, e);
            check("pop_instr", {32'h0, if_instr}, {32'h0, exp_instr(e)});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) tick();
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic restart();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
      reset          = 1'b1;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      @(posedge clk);
      #1;
      check("rst_valid", if_valid, 0);
      check("rst_instr", if_instr, 0);
      check("rst_pc", if_pc, 0);
      check("rst_fault", fetch_fault, 0);
      check("rst_addr", imem_addr, 64'h0);

      // Streaming from reset release with decode always ready
      reset    = 1'b0;
      if_ready = 1'b1;
      sb.push_back(64'd0); sb.push_back(64'd4); sb.push_back(64'd8); sb.push_back(64'd12);
      check("s1_pre_valid", if_valid, 0);
      tick();
      check("s1_first_valid", if_valid, 1);
      check("s1_first_pc", if_pc, 64'd0);
      tick(); tick(); tick();
      check("s1_addr16", imem_addr, 64'd16);
      check("s1_no_fault_yet", fetch_fault, 0);
      tick();
      check("s1_fault", fetch_fault, 1);
      check("s1_valid_drop", if_valid, 0);
      check("s1_sb_empty", 64'(sb.size()), 64'd0);
      tick();
      check("s1_fault_sticky", fetch_fault, 1);

      // Backpressure fills the queue, then release delivers in order
      if_ready = 1'b0;
      restart();
      repeat (6) tick();
      check("s2_full_valid", if_valid, 1);
      check("s2_head_pc", if_pc, 64'd0);
      check("s2_addr_hold", imem_addr, 64'd8);
      check("s2_no_fault", fetch_fault, 0);
      sb.push_back(64'd0); sb.push_back(64'd4); sb.push_back(64'd8); sb.push_back(64'd12);
      if_ready = 1'b1;
      drain(12);
      check("s2_fault_end", fetch_fault, 1);

      // Redirect flushes queued entries
      if_ready = 1'b0;
      restart();
      repeat (4) tick();
      check("s3_head_pc", if_pc, 64'd0);
      check("s3_addr", imem_addr, 64'd8);
      redirect_valid = 1'b1;
      redirect_pc    = 64'd8;
      sb.push_back(64'd8); sb.push_back(64'd12);
      tick();
      redirect_valid = 1'b0;
      check("s3_flushed", if_valid, 0);
      check("s3_addr_target", imem_addr, 64'd8);
      if_ready = 1'b1;
      tick();
      check("s3_valid_n2", if_valid, 1);
      check("s3_pc_n2", if_pc, 64'd8);
      drain(10);

      // Misaligned target faults; back-to-back redirects, last one wins
      redirect_valid = 1'b1;
      redirect_pc    = 64'd6;
      tick();
      redirect_valid = 1'b0;
      check("s4_fault_cleared", fetch_fault, 0);
      check("s4_addr6", imem_addr, 64'd6);
      tick();
      check("s4_misalign_fault", fetch_fault, 1);
      check("s4_no_push", if_valid, 0);
      check("s4_addr_hold", imem_addr, 64'd6);
      redirect_valid = 1'b1;
      redirect_pc    = 64'd0;
      tick();
      redirect_pc = 64'd4;
      sb.push_back(64'd4); sb.push_back(64'd8); sb.push_back(64'd12);
      tick();
      redirect_valid = 1'b0;
      check("s4_fault_exit", fetch_fault, 0);
      check("s4_addr4", imem_addr, 64'd4);
      check("s4_b2b_no_push", if_valid, 0);
      drain(10);

      // Async reset mid-cycle with a full queue and a raised fault
      if_ready       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'd8;
      tick();
      redirect_valid = 1'b0;
      tick(); tick(); tick();
      check("s5_pre_fault", fetch_fault, 1);
      check("s5_pre_valid", if_valid, 1);
      check("s5_pre_pc", if_pc, 64'd8);
      #2;
      reset = 1'b1;
      #1;
      check("s5_async_valid", if_valid, 0);
      check("s5_async_pc", if_pc, 0);
      check("s5_async_instr", if_instr, 0);
      check("s5_async_fault", fetch_fault, 0);
      check("s5_async_addr", imem_addr, 64'h0);
      tick();
      reset    = 1'b0;
      if_ready = 1'b1;
      sb.push_back(64'd0); sb.push_back(64'd4); sb.push_back(64'd8); sb.push_back(64'd12);
      drain(12);

      // Full queue streaming, then a redirect on a push/pop cycle
      if_ready = 1'b0;
      restart();
      repeat (3) tick();
      sb.push_back(64'd0); sb.push_back(64'd4);
      if_ready = 1'b1;
      tick();
      check("s6_stream_valid", if_valid, 1);
      check("s6_stream_pc", if_pc, 64'd4);
      check("s6_stream_addr", imem_addr, 64'd12);
      redirect_valid = 1'b1;
      redirect_pc    = 64'd0;
      tick();
      redirect_valid = 1'b0;
      check("s6_pop_delivered", 64'(sb.size()), 64'd0);
      check("s6_push_dropped", if_valid, 0);
      check("s6_addr_target", imem_addr, 64'd0);
      sb.push_back(64'd0); sb.push_back(64'd4); sb.push_back(64'd8); sb.push_back(64'd12);
      drain(12);
      tick();
      check("s6_final_valid", if_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_controller.md
Name: instruction_fetch_controller

Overview:
- Sequences the combinational, byte-addressed instruction memory.
- Owns the fetch PC and drives the memory address.
- Captures each 32-bit instruction with its PC into a small queue and hands it to decode over a valid/ready handshake.
- Handles branch/jump redirects (queue flush) and out-of-range or misaligned fetch faults. Sits between instruction memory and the IF/ID pipeline register.

Parameters:
- RESET_PC, 64'h0: fetch PC after reset.
- QUEUE_DEPTH, 2: instruction queue entries; power of 2, ≥2.
- MEM_BYTES, 16: instruction memory size in bytes; last legal fetch PC is MEM_BYTES-4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  64  byte address to instruction memory; equals fetch_pc combinationally.
- imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle, little-endian assembled.
- redirect_valid  input  1  redirect request from execute (taken branch/jump).
- redirect_pc  input  64  redirect target.
- if_valid  output  1  queue head holds a valid instruction.
- if_ready  input  1  decode accepts the head this cycle.
- if_instr  output  32  head instruction.
- if_pc  output  64  head PC.
- fetch_fault  output  1  sticky fault flag.

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, queue empty, state=RUN. Outputs: if_valid=0, if_instr=0, if_pc=0, fetch_fault=0, imem_addr=RESET_PC.
- States: RUN, FAULT.
- Pop: if_valid && if_ready at a rising edge removes the head. When the queue is empty, if_instr and if_pc read 0.
- Push (RUN, no redirect): when fetch_pc is legal and the queue has space after this cycle's pop, write {fetch_pc, imem_rdata} at the tail and set fetch_pc += 4.
  - Space is "count < QUEUE_DEPTH, or a pop occurs this cycle", so a full queue with if_ready=1 sustains 1 instr/cycle.
- Legal fetch_pc: fetch_pc[1:0]==0 and fetch_pc <= MEM_BYTES-4, with an unsigned 64-bit compare.
- RUN -> FAULT: an illegal fetch_pc with no redirect.
  - No push occurs and fetch_fault=1 from the next cycle.
  - fetch_pc holds.
  - The queue keeps draining normally.
- FAULT: no pushes. Exit only by a redirect.
- Redirect (either state, highest priority):
  - The handshake in the redirect cycle still completes; the consumer keeps that instruction.
  - At the edge: the queue is cleared (count=0, pointers reset), fetch_pc=redirect_pc, state=RUN, fetch_fault=0, and nothing is pushed.
  - A target that is itself illegal moves to FAULT one cycle later via the normal rule.
- Redirect latency: redirect asserted in cycle N gives imem_addr=target in N+1, a push at the end of N+1, and if_valid=1 with if_pc=target in N+2.
- Reset-release latency: first push at the first edge after reset deasserts; if_valid=1 one cycle after that.
- Queue pointers wrap modulo QUEUE_DEPTH. The count is clog2(QUEUE_DEPTH)+1 bits wide.
- PC arithmetic is 64-bit modulo 2^64. Overflow is unreachable because the fault check precedes increment.
- Back-to-back redirects: the last one wins. Each redirect flushes.

Decomposition:
- Package riscv_fetch_pkg:
  - XLEN=64, ILEN=32, PC_STEP=4.
  - fetch_state_t enum {RUN, FAULT}.
  - fetch_entry_t struct {pc[63:0], instr[31:0]}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and count outputs. Async active-high reset on clk/reset. Flush has priority over push; pop is allowed in the flush cycle.

Test Plan:
- Reset release, if_ready=1, 16-byte memory preloaded:
  - if_pc sequence 0,4,8,12 on consecutive cycles, if_valid first high 1 cycle after the first push.
  - At fetch_pc=16, fetch_fault=1; if_valid drops after pc 12 pops.
- if_ready=0 for 6 cycles after reset:
  - Queue fills with pc 0,4; fetch_pc/imem_addr hold at 8.
  - Raising if_ready delivers 0,4,8,12 with no loss or duplicates.
- Queue holding pc 0,4, redirect_valid=1, redirect_pc=8:
  - Entries 0,4 discarded after the edge, if_valid=0 for one cycle.
  - if_pc=8 two cycles after the redirect.
- Redirect to pc 6 (misaligned):
  - fetch_fault=1 the cycle after fetch_pc=6, no push.
  - A later redirect to 4 clears the fault and delivers pc 4 then 8.
- Async reset pulse mid-cycle with the queue full:
  - if_valid, if_pc, if_instr and fetch_fault go to 0 immediately, imem_addr=RESET_PC.
  - Fetch restarts cleanly.
- Full queue with if_ready held 1 and a simultaneous push/pop:
  - One instruction per cycle, count stays at QUEUE_DEPTH.
  - Redirect in the same cycle: the popped instruction is delivered and the pushed one is dropped.
